pc_fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and issues fetch requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents OpCode/Funct to the decoder.
- At the end of each execute cycle, selects the next PC from the decoder's PCSrc/Branch outputs and the ALU Zero flag.

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage placed directly in front of the control decoder.
// It holds the PC and fetches one word at a time from instruction memory over
// a req/ack handshake. It latches the word into the instruction register.
// Once the instruction has executed, it selects the next PC from the
// decoder's PCSrc/Branch outputs and the ALU Zero flag.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   imem_req/addr     : fetch request and address (address is always PC)
//   imem_ack/rdata    : memory handshake return and instruction word
//   PCSrc, Branch     : next-PC select from the decoder
//   Zero              : ALU equality flag for conditional branches
//   rs_data           : register-jump target
//   PC, PC_plus_4     : current PC and its sequential successor
//   Instruction       : instruction register, with OpCode/Funct fields
//   instr_valid       : high during the execute cycle
//   pc_misalign       : pulse after a register jump to an unaligned target
//   illegal_pcsrc     : pulse after an execute cycle with reserved PCSrc
//   retired           : count of completed execute cycles
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   input  logic [1:0]       PCSrc,
   input  logic             Branch,
   input  logic             Zero,
   input  logic [31:0]      rs_data,
   output logic [31:0]      PC,
   output logic [31:0]      PC_plus_4,
   output logic [31:0]      Instruction,
   output logic [5:0]       OpCode,
   output logic [5:0]       Funct,
   output logic             instr_valid,
   output logic             pc_misalign,
   output logic             illegal_pcsrc,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state;
   logic signed [31:0] br_off;
   logic [31:0]        br_target;
   logic [31:0]        j_target;
   logic [31:0]        next_pc;

   assign imem_req    = (state != S_EXEC);
   assign imem_addr   = PC;
   assign instr_valid = (state == S_EXEC);
   assign OpCode      = Instruction[31:26];
   assign Funct       = Instruction[5:0];

   always_comb begin
      PC_plus_4 = PC + 32'd4;
      // Word offset: sign-extend the 16-bit immediate, then scale by 4.
      br_off    = signed'({{14{Instruction[15]}}, Instruction[15:0], 2'b00});
      br_target = PC_plus_4 + $unsigned(br_off);
      j_target  = {PC_plus_4[31:28], Instruction[25:0], 2'b00};

      next_pc = PC_plus_4;
      unique case (PCSrc)
         2'b01:   next_pc = j_target;
         2'b10:   next_pc = {rs_data[31:2], 2'b00};
         2'b11:   next_pc = PC_plus_4;
         default: next_pc = (Branch && Zero) ? br_target : PC_plus_4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         PC            <= RESET_PC;
         Instruction   <= 32'd0;
         retired       <= '0;
         pc_misalign   <= 1'b0;
         illegal_pcsrc <= 1'b0;
      end else begin
         // Flags are one-cycle pulses; only the execute edge sets them.
         pc_misalign   <= 1'b0;
         illegal_pcsrc <= 1'b0;
         unique case (state)
            S_FETCH, S_WAIT: begin
               if (imem_ack) begin
                  Instruction <= imem_rdata;
                  state       <= S_EXEC;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_EXEC: begin
               PC            <= next_pc;
               retired       <= retired + CNT_ONE;
               pc_misalign   <= (PCSrc == 2'b10) && (rs_data[1:0] != 2'b00);
               illegal_pcsrc <= (PCSrc == 2'b11);
               state         <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
